// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and the access legality/alignment check.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // True when funct3 is legal for the direction and the address is naturally aligned.
  function automatic logic access_ok(input logic [2:0] funct3,
                                     input logic       isStore,
                                     input logic [1:0] addrLo);
    logic legal;
    logic aligned;
    if (isStore)
      legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    else
      legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
              (funct3 == F3_LBU) || (funct3 == F3_LHU);
    case (funct3[1:0])
      2'b01:   aligned = !addrLo[0];
      2'b10:   aligned = (addrLo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/grant/read-valid bus between the LSU (master) and memory (slave).
interface lsu_dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// lane selection with sign or zero extension for load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = '0;
    if (is_store_i) begin
      case (funct3_i)
        F3_SB: begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{store_data_i[7:0]}};
        end
        F3_SH: begin
          be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
          wdata_o = {2{store_data_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = store_data_i;
        end
      endcase
    end
  end

  always_comb begin
    case (addr_lo_i)
      2'd0:    byteLane = rdata_i[7:0];
      2'd1:    byteLane = rdata_i[15:8];
      2'd2:    byteLane = rdata_i[23:16];
      default: byteLane = rdata_i[31:24];
    endcase
    halfLane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   load_data_o = {{24{byteLane[7]}}, byteLane};
      F3_LH:   load_data_o = {{16{halfLane[15]}}, halfLane};
      F3_LBU:  load_data_o = {24'h0, byteLane};
      F3_LHU:  load_data_o = {16'h0, halfLane};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: checks and latches an EX-stage load/store, runs it over
// the req/gnt/rvalid bus while stalling the pipeline, and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_funct3,
  input  logic [31:0]           ex_address,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  output logic                  lsu_stall,
  output logic                  lsu_done,
  output logic                  lsu_fault,
  output logic [DATA_WIDTH-1:0] lsu_load_data,
  lsu_dmem_if.master            dmem
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] storeData_q;
  logic        isStore_q;
  logic [31:0] loadData_q;
  logic [31:0] count_q, count_d;

  logic        reqValid;
  logic        accessOk;
  logic        timeoutHit;
  logic        captureLoad;
  logic [3:0]  alignBe;
  logic [31:0] alignWdata;
  logic [31:0] alignLoadData;

  assign reqValid   = ex_valid & (ex_mem_read | ex_mem_write);
  assign accessOk   = access_ok(ex_funct3, ex_mem_write, ex_address[1:0]);
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && (count_q == 32'(TIMEOUT_CYCLES - 1));
  // A read response counts only while a load is outstanding; late rvalid is dropped.
  assign captureLoad = !isStore_q && dmem.rvalid &&
                       (((state_q == S_REQ) && dmem.gnt) || (state_q == S_WAIT));
  assign count_d     = ((state_q == S_REQ) || (state_q == S_WAIT)) ? count_q + 32'd1 : '0;
  assign lsu_load_data = loadData_q;

  lsu_align u_align (
    .is_store_i   (isStore_q),
    .funct3_i     (funct3_q),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (storeData_q),
    .rdata_i      (dmem.rdata),
    .be_o         (alignBe),
    .wdata_o      (alignWdata),
    .load_data_o  (alignLoadData)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= '0;
      funct3_q    <= '0;
      storeData_q <= '0;
      isStore_q   <= 1'b0;
      loadData_q  <= '0;
      count_q     <= '0;
    end else begin
      count_q <= count_d;
      if ((state_q == S_IDLE) && reqValid && accessOk) begin
        addr_q      <= ex_address;
        funct3_q    <= ex_funct3;
        storeData_q <= ex_store_data;
        isStore_q   <= ex_mem_write;
      end
      if (captureLoad) loadData_q <= alignLoadData;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (reqValid) state_d = accessOk ? S_REQ : S_ERR;
      end
      S_REQ: begin
        if (dmem.gnt) begin
          if (isStore_q || dmem.rvalid) state_d = S_DONE;
          else                          state_d = S_WAIT;
        end else if (timeoutHit) begin
          state_d = S_ERR;
        end
      end
      S_WAIT: begin
        if (dmem.rvalid)     state_d = S_DONE;
        else if (timeoutHit) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are forced to zero outside REQ so memory only sees the held request.
  always_comb begin
    lsu_stall  = 1'b0;
    lsu_done   = 1'b0;
    lsu_fault  = 1'b0;
    dmem.req   = 1'b0;
    dmem.we    = 1'b0;
    dmem.addr  = '0;
    dmem.be    = '0;
    dmem.wdata = '0;
    case (state_q)
      S_IDLE: lsu_stall = reqValid;
      S_REQ: begin
        lsu_stall  = 1'b1;
        dmem.req   = 1'b1;
        dmem.we    = isStore_q;
        dmem.addr  = {addr_q[31:2], 2'b00};
        dmem.be    = alignBe;
        dmem.wdata = alignWdata;
      end
      S_WAIT: lsu_stall = 1'b1;
      S_DONE: lsu_done  = 1'b1;
      S_ERR: begin
        lsu_done  = 1'b1;
        lsu_fault = 1'b1;
      end
      default: lsu_stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; memory responses are driven
// by hand each cycle and every expectation is a hand-computed constant.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = 3'b0;
  logic [31:0] ex_address = 32'h0;
  logic [31:0] ex_store_data = 32'h0;
  logic        lsu_stall;
  logic        lsu_done;
  logic        lsu_fault;
  logic [31:0] lsu_load_data;
  int          numChecks = 0;
  int          numFails = 0;

  lsu_dmem_if dmem();

  load_store_unit #(.TIMEOUT_CYCLES(4), .DATA_WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .ex_address    (ex_address),
    .ex_store_data (ex_store_data),
    .lsu_stall     (lsu_stall),
    .lsu_done      (lsu_done),
    .lsu_fault     (lsu_fault),
    .lsu_load_data (lsu_load_data),
    .dmem          (dmem)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    numChecks++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    ex_valid      = v;
    ex_mem_read   = rd;
    ex_mem_write  = wr;
    ex_funct3     = f3;
    ex_address    = a;
    ex_store_data = d;
  endtask

  // Store with grant in the first REQ cycle; done lands two cycles after the request.
  task automatic runStore(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] expBe, input logic [31:0] expWdata);
    applyStimulus(1'b1, 1'b0, 1'b1, f3, a, d);
    #1;
    checkFlag({tag, " stall idle"}, lsu_stall, 1'b1);
    checkFlag({tag, " req idle"}, dmem.req, 1'b0);
    nextCycle();
    dmem.gnt = 1'b1;
    #1;
    checkFlag({tag, " req"}, dmem.req, 1'b1);
    checkFlag({tag, " we"}, dmem.we, 1'b1);
    checkFlag({tag, " stall req"}, lsu_stall, 1'b1);
    checkOutput({tag, " addr"}, dmem.addr, {a[31:2], 2'b00});
    checkOutput({tag, " be"}, {28'h0, dmem.be}, {28'h0, expBe});
    checkOutput({tag, " wdata"}, dmem.wdata, expWdata);
    nextCycle();
    dmem.gnt = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkFlag({tag, " done"}, lsu_done, 1'b1);
    checkFlag({tag, " fault"}, lsu_fault, 1'b0);
    checkFlag({tag, " stall done"}, lsu_stall, 1'b0);
    checkFlag({tag, " req done"}, dmem.req, 1'b0);
    nextCycle();
  endtask

  // Load granted in the first REQ cycle; rvalid arrives gap cycles after the grant.
  task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input int gap, input logic [31:0] expData);
    applyStimulus(1'b1, 1'b1, 1'b0, f3, a, 32'h0);
    #1;
    checkFlag({tag, " stall idle"}, lsu_stall, 1'b1);
    nextCycle();
    dmem.gnt = 1'b1;
    if (gap == 0) begin
      dmem.rvalid = 1'b1;
      dmem.rdata  = rd;
    end
    #1;
    checkFlag({tag, " req"}, dmem.req, 1'b1);
    checkFlag({tag, " we"}, dmem.we, 1'b0);
    checkOutput({tag, " addr"}, dmem.addr, {a[31:2], 2'b00});
    checkOutput({tag, " be"}, {28'h0, dmem.be}, 32'h0000000F);
    nextCycle();
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = 32'h0;
    for (int i = 1; i <= gap; i++) begin
      if (i == gap) begin
        dmem.rvalid = 1'b1;
        dmem.rdata  = rd;
      end
      #1;
      checkFlag({tag, " req wait"}, dmem.req, 1'b0);
      checkFlag({tag, " stall wait"}, lsu_stall, 1'b1);
      checkFlag({tag, " done wait"}, lsu_done, 1'b0);
      nextCycle();
      dmem.rvalid = 1'b0;
      dmem.rdata  = 32'h0;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkFlag({tag, " done"}, lsu_done, 1'b1);
    checkFlag({tag, " fault"}, lsu_fault, 1'b0);
    checkFlag({tag, " stall done"}, lsu_stall, 1'b0);
    checkOutput({tag, " data"}, lsu_load_data, expData);
    nextCycle();
  endtask

  // Rejected request: no bus activity, fault pulse next cycle, load data untouched.
  task automatic runFault(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] expHeld);
    applyStimulus(1'b1, rd, wr, f3, a, 32'h0);
    #1;
    checkFlag({tag, " stall idle"}, lsu_stall, 1'b1);
    checkFlag({tag, " req idle"}, dmem.req, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkFlag({tag, " req err"}, dmem.req, 1'b0);
    checkFlag({tag, " done"}, lsu_done, 1'b1);
    checkFlag({tag, " fault"}, lsu_fault, 1'b1);
    checkFlag({tag, " stall err"}, lsu_stall, 1'b0);
    checkOutput({tag, " data held"}, lsu_load_data, expHeld);
    nextCycle();
    checkFlag({tag, " done cleared"}, lsu_done, 1'b0);
  endtask

  initial begin
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = 32'h0;

    repeat (2) @(posedge clock);
    #1;
    checkFlag("reset stall", lsu_stall, 1'b0);
    checkFlag("reset done", lsu_done, 1'b0);
    checkFlag("reset fault", lsu_fault, 1'b0);
    checkOutput("reset load_data", lsu_load_data, 32'h0);
    checkFlag("reset req", dmem.req, 1'b0);
    checkFlag("reset we", dmem.we, 1'b0);
    checkOutput("reset addr", dmem.addr, 32'h0);
    checkOutput("reset be", {28'h0, dmem.be}, 32'h0);
    checkOutput("reset wdata", dmem.wdata, 32'h0);
    reset = 1'b0;

    runStore("SW", F3_SW, 32'h00000100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    runStore("SB", F3_SB, 32'h00000103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    runStore("SH", F3_SH, 32'h00000102, 32'h00001234, 4'b1100, 32'h12341234);

    runLoad("LB", F3_LB, 32'h00000102, 32'h80FF7F01, 1, 32'hFFFFFFFF);
    runLoad("LBU", F3_LBU, 32'h00000102, 32'h80FF7F01, 0, 32'h000000FF);
    runLoad("LH", F3_LH, 32'h00000102, 32'h80FF7F01, 2, 32'hFFFF80FF);
    runLoad("LHU", F3_LHU, 32'h00000100, 32'h80FF7F01, 3, 32'h00007F01);
    runLoad("LW", F3_LW, 32'h00000100, 32'h80FF7F01, 3, 32'h80FF7F01);
    checkOutput("LW data held idle", lsu_load_data, 32'h80FF7F01);

    runFault("LW misaligned", 1'b1, 1'b0, F3_LW, 32'h00000102, 32'h80FF7F01);
    runFault("LH misaligned", 1'b1, 1'b0, F3_LH, 32'h00000101, 32'h80FF7F01);
    runFault("load f3 011", 1'b1, 1'b0, 3'b011, 32'h00000100, 32'h80FF7F01);
    runFault("store f3 100", 1'b0, 1'b1, 3'b100, 32'h00000100, 32'h80FF7F01);

    // Grant never arrives: four REQ cycles then a fault.
    applyStimulus(1'b1, 1'b1, 1'b0, F3_LW, 32'h00000200, 32'h0);
    #1;
    checkFlag("TO stall idle", lsu_stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkFlag("TO req held", dmem.req, 1'b1);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    checkFlag("TO req dropped", dmem.req, 1'b0);
    checkFlag("TO done", lsu_done, 1'b1);
    checkFlag("TO fault", lsu_fault, 1'b1);
    checkOutput("TO data held", lsu_load_data, 32'h80FF7F01);
    nextCycle();
    checkFlag("TO done cleared", lsu_done, 1'b0);

    // Reset while waiting for read data, then a stray rvalid.
    applyStimulus(1'b1, 1'b1, 1'b0, F3_LW, 32'h00000300, 32'h0);
    nextCycle();
    dmem.gnt = 1'b1;
    #1;
    checkFlag("RST req", dmem.req, 1'b1);
    nextCycle();
    dmem.gnt = 1'b0;
    #1;
    checkFlag("RST wait req", dmem.req, 1'b0);
    checkFlag("RST wait stall", lsu_stall, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    reset = 1'b0;
    #1;
    checkFlag("RST stall", lsu_stall, 1'b0);
    checkFlag("RST done", lsu_done, 1'b0);
    checkFlag("RST req", dmem.req, 1'b0);
    checkOutput("RST load_data", lsu_load_data, 32'h0);
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'h55AA55AA;
    nextCycle();
    dmem.rvalid = 1'b0;
    dmem.rdata  = 32'h0;
    #1;
    checkOutput("late rvalid data", lsu_load_data, 32'h0);
    checkFlag("late rvalid done", lsu_done, 1'b0);
    checkFlag("late rvalid stall", lsu_stall, 1'b0);

    runLoad("LW gnt+rvalid", F3_LW, 32'h00000104, 32'h11223344, 0, 32'h11223344);

    runStore("B2B SW", F3_SW, 32'h00000108, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    runLoad("B2B LW", F3_LW, 32'h00000108, 32'hCAFEF00D, 1, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no completion, expected end of directed sequence");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 store data and funct3 from the EX stage.
- Performs byte/half/word loads and stores over a req/gnt/rvalid data-memory interface.
- Stalls the pipeline until the access completes, and returns sign/zero-extended load data for write-back.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed in REQ+WAIT before fault; 0 disables the timeout
DATA_WIDTH, 32, fixed datapath width; only 32 is supported

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
ex_valid  input  1  EX stage presents a memory op this cycle
ex_mem_read  input  1  load request
ex_mem_write  input  1  store request (has priority if both are set)
ex_funct3  input  3  access width/sign (RV32I load/store funct3)
ex_address  input  32  effective address (ALU_result)
ex_store_data  input  32  rs2 value
lsu_stall  output  1  hold upstream stages; EX inputs must stay stable while high
lsu_done  output  1  one-cycle completion pulse
lsu_fault  output  1  with lsu_done: misaligned, illegal funct3 or timeout
lsu_load_data  output  32  extended load result; held until next load completes
dmem_req  output  1  memory request
dmem_we  output  1  write enable
dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_gnt  input  1  request accepted
dmem_rvalid  input  1  read data valid
dmem_rdata  input  32  read data

Behaviour:
- States: IDLE, REQ, WAIT, DONE, ERR. Reset puts the FSM in IDLE and drives all outputs 0, including lsu_load_data.
- IDLE: an op is a request when ex_valid & (read|write).
  - Fault checks: illegal funct3 (load 011/110/111; store >=011), half with addr[0]=1, or word with addr[1:0]!=0 -> ERR. No dmem_req is issued.
  - Otherwise latch address, funct3, be, wdata and direction, then go to REQ.
  - ex_valid is ignored in every state except IDLE.
- lsu_stall is combinational: 1 in IDLE when a request is present, and 1 in REQ and WAIT. It is 0 in DONE and ERR, so the pipeline advances on the completion cycle.
- REQ: dmem_req=1 with addr/we/be/wdata held constant until dmem_gnt.
  - On gnt for a store -> DONE.
  - On gnt for a load -> WAIT, or straight to DONE if dmem_rvalid is asserted in the same cycle (data captured).
- WAIT: dmem_req=0. On dmem_rvalid, capture and extract data -> DONE.
- DONE: lsu_done=1 for one cycle; return to IDLE. Minimum latency: request cycle -> lsu_done 2 cycles later for a store with immediate gnt.
- ERR: lsu_done=1 and lsu_fault=1 for one cycle; lsu_load_data is unchanged; return to IDLE.
- Timeout: a counter is cleared on entry to REQ and increments in REQ and WAIT. When TIMEOUT_CYCLES!=0 and count==TIMEOUT_CYCLES-1 with no progress -> ERR, dropping dmem_req.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{d[15:0]}}.
  - SW: be=4'b1111, wdata=d.
- Load extraction: select the lane by addr[1:0].
  - LB (000) and LH (001) sign-extend; LW (010) is unchanged.
  - LBU (100) and LHU (101) zero-extend.
  - dmem_be=4'b1111 for loads.
- Reset mid-transaction: return to IDLE on that edge with dmem_req=0. A late dmem_rvalid arriving in IDLE/DONE/ERR is ignored.

Decomposition:
- lsu_pkg holds:
  - funct3 constants: LB/LH/LW/LBU/LHU/SB/SH/SW.
  - the state encoding.
  - the alignment-check function.
- One combinational sub-module, lsu_align, computes be/wdata from (funct3, addr[1:0], store data) and lsu_load_data from (funct3, addr[1:0], rdata).
- The FSM, latches and timeout counter stay in load_store_unit.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, gnt in REQ -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF; lsu_done 2 cycles after request; stall high exactly 2 cycles.
- SB addr 0x103 data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5. SH addr 0x102 data 0x1234 -> be=1100, wdata=0x12341234.
- Loads with rdata=0x80FF7F01:
  - LB addr 0x102 -> 0xFFFFFFFF; LBU 0x102 -> 0x000000FF.
  - LH 0x102 -> 0xFFFF80FF; LHU 0x100 -> 0x00007F01.
  - LW -> 0x80FF7F01.
  - rvalid 3 cycles after gnt -> done the cycle after rvalid.
- LW addr 0x102, LH addr 0x101, or funct3=011 load -> no dmem_req; lsu_done=lsu_fault=1 next cycle; lsu_load_data unchanged.
- TIMEOUT_CYCLES=4, gnt never asserted -> dmem_req high 4 cycles, then ERR with fault. Repeat with a reset pulse in WAIT -> IDLE, outputs 0, and a later rvalid is ignored.
- gnt and rvalid in the same cycle for LW -> DONE next cycle with correct data; back-to-back store then load both complete in order.
